// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the pipelined exact/approximate unsigned multiplier.
package approx_mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int PW        = 2 * DEF_WIDTH;
    localparam int MAX_W     = 16;

    // Partial-product matrix, row i = multiplier bit, column j = multiplicand bit.
    typedef logic [MAX_W-1:0][MAX_W-1:0] pp_mat_t;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // OR of every partial product whose weight is 2^k.
    function automatic logic col_or(input pp_mat_t pp, input int k, input int w);
        logic r;
        int   j;
        r = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            j = k - i;
            if (i < w && j >= 0 && j < w) begin
                r = r | pp[i][j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/approx_mult_if.sv
// Valid/ready operand and product channels of the approximate multiplier.
interface approx_mult_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_approx;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] out_prod;
    logic               out_approx;

    modport master (
        output in_valid, in_a, in_b, in_approx, out_ready,
        input  in_ready, out_valid, out_prod, out_approx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_approx, out_ready,
        output in_ready, out_valid, out_prod, out_approx
    );
endinterface

// File: rtl/approx_pp_reduce.sv
// Combinational reduction of the PP matrix to two carry-save rows plus an OR-compressed low vector.
module approx_pp_reduce
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_COLS = 8
) (
    input  logic [WIDTH-1:0][WIDTH-1:0] pp,
    input  mode_e                       mode,
    output logic [2*WIDTH-1:0]          sum_row,
    output logic [2*WIDTH-1:0]          carry_row,
    output logic [2*WIDTH-1:0]          low_vec
);

    localparam int PROD_W = 2 * WIDTH;

    function automatic logic [1:0] ha_cell(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // Exact 4:2 compressor: {cout, carry, sum}; cout feeds the next column's cin.
    function automatic logic [2:0] c42_cell(input logic x1, input logic x2, input logic x3,
                                            input logic x4, input logic cin);
        logic [1:0] f1;
        logic [1:0] f2;
        f1 = fa_cell(x1, x2, x3);
        f2 = fa_cell(f1[0], x4, cin);
        return {f1[1], f2[1], f2[0]};
    endfunction

    function automatic logic [2*PROD_W-1:0] ha_rows(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y);
        logic [PROD_W-1:0] s;
        logic [PROD_W:0]   c;
        logic [1:0]        h;
        c = '0;
        for (int k = 0; k < PROD_W; k++) begin
            h        = ha_cell(x[k], y[k]);
            s[k]     = h[0];
            c[k+1]   = h[1];
        end
        return {c[PROD_W-1:0], s};
    endfunction

    function automatic logic [2*PROD_W-1:0] fa_rows(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y,
                                                    input logic [PROD_W-1:0] z);
        logic [PROD_W-1:0] s;
        logic [PROD_W:0]   c;
        logic [1:0]        f;
        c = '0;
        for (int k = 0; k < PROD_W; k++) begin
            f      = fa_cell(x[k], y[k], z[k]);
            s[k]   = f[0];
            c[k+1] = f[1];
        end
        return {c[PROD_W-1:0], s};
    endfunction

    // Carries beyond the top column are dropped: the product is taken mod 2^PROD_W.
    function automatic logic [2*PROD_W-1:0] c42_rows(input logic [PROD_W-1:0] x1,
                                                     input logic [PROD_W-1:0] x2,
                                                     input logic [PROD_W-1:0] x3,
                                                     input logic [PROD_W-1:0] x4);
        logic [PROD_W-1:0] s;
        logic [PROD_W:0]   c;
        logic [2:0]        q;
        logic              cin;
        c   = '0;
        cin = 1'b0;
        for (int k = 0; k < PROD_W; k++) begin
            q      = c42_cell(x1[k], x2[k], x3[k], x4[k], cin);
            s[k]   = q[0];
            c[k+1] = q[1];
            cin    = q[2];
        end
        return {c[PROD_W-1:0], s};
    endfunction

    pp_mat_t           full;
    logic              use_approx;
    logic [PROD_W-1:0] rows [WIDTH];

    always_comb begin
        full       = '0;
        use_approx = (mode == MODE_APPROX) && (APPROX_COLS > 0);
        low_vec    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rows[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                full[i][j] = pp[i][j];
                if (!(use_approx && (i + j) < APPROX_COLS)) begin
                    rows[i][i+j] = pp[i][j];
                end
            end
        end
        for (int k = 0; k < PROD_W; k++) begin
            if (use_approx && k < APPROX_COLS) begin
                low_vec[k] = col_or(full, k, WIDTH);
            end
        end

        sum_row   = rows[0];
        carry_row = '0;
        if (WIDTH > 1) begin
            {carry_row, sum_row} = ha_rows(rows[0], rows[1]);
        end
        for (int r = 2; r + 1 < WIDTH; r += 2) begin
            {carry_row, sum_row} = c42_rows(sum_row, carry_row, rows[r], rows[r+1]);
        end
        if (WIDTH > 2 && (WIDTH % 2) == 1) begin
            {carry_row, sum_row} = fa_rows(sum_row, carry_row, rows[WIDTH-1]);
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// 3-stage valid/ready unsigned multiplier with per-beat exact/approximate mode.
// Optional error monitor (err_cnt/err_max) enabled by defining APPROX_ERR_MON_EN.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_COLS = 8
) (
    input  logic               CLK,
    input  logic               RST_N,
    approx_mult_if.slave       bus,
    output logic [31:0]        op_cnt
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [31:0]        err_cnt,
    output logic [2*WIDTH-1:0] err_max
`endif
);

    localparam int PROD_W = 2 * WIDTH;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [PROD_W-1:0] merge_rows(input logic [PROD_W-1:0] s,
                                                     input logic [PROD_W-1:0] c,
                                                     input logic [PROD_W-1:0] l);
        return s + c + l;
    endfunction

    logic adv;
    logic deliver;
    logic vld_p0, vld_p1, vld_p2;

    logic [WIDTH-1:0][WIDTH-1:0] pp_next, pp_p0;
    mode_e                       mode_in, mode_p0, mode_p1;
    logic [PROD_W-1:0]           sum_row, carry_row, low_vec;
    logic [PROD_W-1:0]           sum_p1, carry_p1, low_p1;
    logic [PROD_W-1:0]           prod_p2;
    logic                        approx_p2;

    // A single advance enable moves every stage together; bubbles stay in place.
    assign adv            = !vld_p2 || bus.out_ready;
    assign deliver        = vld_p2 && bus.out_ready;
    assign bus.in_ready   = adv;
    assign bus.out_valid  = vld_p2;
    assign bus.out_prod   = prod_p2;
    assign bus.out_approx = approx_p2;
    assign mode_in        = bus.in_approx ? MODE_APPROX : MODE_EXACT;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_next[i][j] = bus.in_a[j] & bus.in_b[i];
            end
        end
    end

    approx_pp_reduce #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_reduce (
        .pp        (pp_p0),
        .mode      (mode_p0),
        .sum_row   (sum_row),
        .carry_row (carry_row),
        .low_vec   (low_vec)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            prod_p2   <= '0;
            approx_p2 <= 1'b0;
            op_cnt    <= '0;
        end else begin
            if (adv) begin
                vld_p0 <= bus.in_valid;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
            end
            // Stage 3: final carry-propagate add of S, C and the OR vector.
            if (adv && vld_p1) begin
                prod_p2   <= merge_rows(sum_p1, carry_p1, low_p1);
                approx_p2 <= (mode_p1 == MODE_APPROX);
            end
            if (deliver) begin
                op_cnt <= op_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (adv) begin
            // Stage 1: partial-product matrix and mode.
            pp_p0    <= pp_next;
            mode_p0  <= mode_in;
            // Stage 2: carry-save rows and OR-compressed low columns.
            sum_p1   <= sum_row;
            carry_p1 <= carry_row;
            low_p1   <= low_vec;
            mode_p1  <= mode_p0;
        end
    end

`ifdef APPROX_ERR_MON_EN
    logic [PROD_W-1:0] exact_p0, exact_p1, exact_p2;
    logic [PROD_W-1:0] err_abs;

    assign err_abs = (exact_p2 >= prod_p2) ? exact_p2 - prod_p2 : prod_p2 - exact_p2;

    always_ff @(posedge CLK) begin
        if (adv) begin
            exact_p0 <= PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
            exact_p1 <= exact_p0;
        end
        if (adv && vld_p1) begin
            exact_p2 <= exact_p1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (deliver && approx_p2 && (prod_p2 != exact_p2)) begin
            err_cnt <= sat_inc32(err_cnt);
            if (err_abs > err_max) begin
                err_max <= err_abs;
            end
        end
    end
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench: directed vectors on an APPROX_COLS=8 instance, random exact checks on an APPROX_COLS=0 instance.
module tb_approx_mult_pipe;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef struct packed {
        logic [PW-1:0] prod;
        logic          approx;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    approx_mult_if #(.WIDTH(W)) bus1 ();
    approx_mult_if #(.WIDTH(W)) bus2 ();

    logic [31:0] op_cnt1, op_cnt2;
`ifdef APPROX_ERR_MON_EN
    logic [31:0] err_cnt1, err_cnt2;
    logic [PW-1:0] err_max1, err_max2;
`endif

    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(8)) dut1 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus    (bus1),
        .op_cnt (op_cnt1)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_cnt (err_cnt1),
        .err_max (err_max1)
`endif
    );

    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(0)) dut2 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus    (bus2),
        .op_cnt (op_cnt2)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_cnt (err_cnt2),
        .err_max (err_max2)
`endif
    );

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int   total = 0;
    int   bad   = 0;
    logic done6 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut1_unexpected_beat actual=%0d required=none", bus1.out_prod);
            end else begin
                e1 = q1.pop_front();
                check("dut1_prod", bus1.out_prod, e1.prod);
                check("dut1_mode", bus1.out_approx, e1.approx);
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dut2_unexpected_beat actual=%0d required=none", bus2.out_prod);
            end else begin
                e2 = q2.pop_front();
                check("dut2_prod", bus2.out_prod, e2.prod);
                check("dut2_mode", bus2.out_approx, e2.approx);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic [PW-1:0] p);
        bit ok;
        ok = 1'b0;
        if (d == 1) begin
            bus1.in_a = a; bus1.in_b = b; bus1.in_approx = m; bus1.in_valid = 1'b1;
        end else begin
            bus2.in_a = a; bus2.in_b = b; bus2.in_approx = m; bus2.in_valid = 1'b1;
        end
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if ((d == 1) ? bus1.in_ready : bus2.in_ready) begin
                if (d == 1) q1.push_back('{prod: p, approx: m});
                else        q2.push_back('{prod: p, approx: m});
                ok = 1'b1;
                @(posedge CLK);
                #1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (d == 1) bus1.in_valid = 1'b0;
        else        bus2.in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut=%0d actual=no_accept required=accept", d);
        end
    endtask

    task automatic drain(input int d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge CLK);
            if (((d == 1) ? q1.size() : q2.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL drain_timeout dut=%0d actual=pending required=empty", d);
        end
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        q1.delete();
        q2.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    logic [W-1:0]  da [12] = '{8'd3, 8'd3, 8'd255, 8'd255, 8'd1, 8'd15, 8'd15, 8'd170, 8'd170, 8'd128, 8'd0, 8'd16};
    logic [W-1:0]  db [12] = '{8'd3, 8'd3, 8'd255, 8'd255, 8'd200, 8'd15, 8'd15, 8'd85, 8'd85, 8'd255, 8'd77, 8'd16};
    logic          dm [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [PW-1:0] dp [12] = '{16'd7, 16'd9, 16'd63487, 16'd65025, 16'd200, 16'd127, 16'd225,
                               16'd13994, 16'd14450, 16'd32640, 16'd0, 16'd256};

    logic [W-1:0]  sa [5] = '{8'd12, 8'd200, 8'd99, 8'd7, 8'd255};
    logic [W-1:0]  sb [5] = '{8'd11, 8'd3, 8'd99, 8'd250, 8'd1};
    logic [PW-1:0] sp [5] = '{16'd132, 16'd600, 16'd9801, 16'd1750, 16'd255};

    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic rm;

        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_approx = 1'b0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_approx = 1'b0; bus2.out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        check("rst_out_valid", bus1.out_valid, 0);
        check("rst_in_ready", bus1.in_ready, 1);
        check("rst_out_prod", bus1.out_prod, 0);
        check("rst_out_approx", bus1.out_approx, 0);
        check("rst_op_cnt", op_cnt1, 0);
        @(posedge CLK);
        #1;

        // Latency from an empty pipe: result visible after the third rising edge.
        q1.push_back('{prod: 16'd7, approx: 1'b1});
        bus1.in_a = 8'd3; bus1.in_b = 8'd3; bus1.in_approx = 1'b1; bus1.in_valid = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge CLK);
            #1;
            bus1.in_valid = 1'b0;
            if (bus1.out_valid) begin
                lat = n;
                break;
            end
        end
        check("latency", lat, 3);
        drain(1);

        for (int i = 0; i < 12; i++) send(1, da[i], db[i], dm[i], dp[i]);
        drain(1);
        check("op_cnt_directed", op_cnt1, 13);

        pulse_reset();
        check("op_cnt_after_reset", op_cnt1, 0);
        fork
            begin
                for (int i = 0; i < 5; i++) send(1, sa[i], sb[i], 1'b0, sp[i]);
            end
            begin
                repeat (4) @(posedge CLK);
                #1;
                bus1.out_ready = 1'b0;
                for (int n = 0; n < 4; n++) begin
                    @(negedge CLK);
                    check("stall_in_ready", bus1.in_ready, 0);
                    check("stall_out_valid", bus1.out_valid, 1);
                    check("stall_hold_prod", bus1.out_prod, (q1.size() > 0) ? q1[0].prod : 16'hDEAD);
                end
                @(posedge CLK);
                #1;
                bus1.out_ready = 1'b1;
            end
        join
        drain(1);
        check("op_cnt_stall", op_cnt1, 5);
        check("stall_queue_empty", q1.size(), 0);

        send(1, 8'd3, 8'd3, 1'b0, 16'd9);
        send(1, 8'd4, 8'd5, 1'b0, 16'd20);
        send(1, 8'd6, 8'd7, 1'b0, 16'd42);
        RST_N = 1'b0;
        q1.delete();
        @(negedge CLK);
        check("flush_out_valid", bus1.out_valid, 0);
        check("flush_op_cnt", op_cnt1, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            check("post_flush_idle", bus1.out_valid, 0);
        end
        @(posedge CLK);
        #1;

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    rm = 1'($urandom_range(0, 1));
                    send(2, ra, rb, rm, 16'(ra) * 16'(rb));
                end
                done6 = 1'b1;
            end
            begin
                while (!done6) begin
                    @(posedge CLK);
                    #1;
                    bus2.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus2.out_ready = 1'b1;
        drain(2);
        check("dut2_op_cnt", op_cnt2, 10000);
`ifdef APPROX_ERR_MON_EN
        check("dut2_err_cnt", err_cnt2, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
